pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
- Sequencing controller for the program-counter register of the 54/55-instruction MIPS core.
- Each cycle it decides whether the PC loads, and with what value: sequential, delayed branch/jump target, exception vector, ERET return, or hold.
- Owns branch-delay-slot tracking, the exception flush bubble, stall and halt.
- Sits between decode/CP0 and the PC register; also drives the EPC/Cause write strobes toward CP0.

Parameters:
- RESET_VECTOR, 32'h00400000, value presented on pc_next during and after reset.
- EXC_VECTOR, 32'h00400004, exception entry address.
- FLUSH_CYCLES, 1, bubble cycles after exception entry (legal 1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_cur  in  32  current PC register value.
- br_taken  in  1  conditional branch at pc_cur resolved taken.
- br_target  in  32  branch target address.
- jmp  in  1  j/jal/jr/jalr at pc_cur.
- jmp_target  in  32  jump target address.
- exc_req  in  1  syscall/break/teq raised by the instruction at pc_cur.
- exc_cause  in  5  ExcCode for exc_req.
- eret  in  1  eret at pc_cur.
- epc_in  in  32  EPC value read from CP0.
- stall_req  in  1  multi-cycle unit (mult/div) busy.
- halt  in  1  stop fetching.
- pc_next  out  32  value for the PC register.
- pc_we  out  1  PC load strobe, active-high.
- epc_out  out  32  value to write into EPC.
- cause_out  out  32  Cause word; ExcCode in bits [6:2], BD in bit 31.
- epc_we  out  1  one-cycle EPC/Cause write strobe.
- state_o  out  2  current state, for debug.

Behaviour:
- States: RUN=0, STALL=1, FLUSH=2, HALT=3.
- Reset: state=RUN, pend_valid=0, pend_target=0, flush_cnt=0.
- While rst=1: pc_we=0, pc_next=RESET_VECTOR, epc_we=0. The first RUN cycle after reset proceeds normally.
- pc_next, pc_we, epc_out, cause_out and epc_we are combinational from state, registers and inputs. They are sampled by the PC register and CP0 at the same edge.
- RUN priority, highest first: exc_req > eret > stall_req > halt > redirect > sequential.
  - exc_req: pc_we=1, pc_next=EXC_VECTOR, epc_we=1.
    - If pend_valid=1 (faulting instruction is in a delay slot): epc_out=pc_cur-4, BD=1.
    - Otherwise: epc_out=pc_cur, BD=0.
    - Clear pend_valid, load flush_cnt=FLUSH_CYCLES, go to FLUSH.
  - eret: pc_we=1, pc_next=epc_in, clear pend_valid.
  - stall_req: pc_we=0, go to STALL; pend state is preserved.
  - halt: pc_we=0, go to HALT.
  - pend_valid=1: pc_we=1, pc_next=pend_target, clear pend_valid. A branch or jump asserted in the delay slot is ignored.
  - br_taken or jmp (jmp wins over br_taken): pc_we=1, pc_next=pc_cur+4, pend_target=chosen target, pend_valid=1.
  - Otherwise: pc_we=1, pc_next=pc_cur+4.
- STALL: pc_we=0, epc_we=0, all other inputs ignored. Return to RUN in the cycle after stall_req drops; that cycle is evaluated as RUN.
- FLUSH: pc_we=0, exc_req/eret/br/jmp ignored. flush_cnt decrements each cycle; go to RUN when it reaches 1.
- HALT: pc_we=0 permanently; only rst exits.
- Arithmetic: pc_cur+4 wraps modulo 2^32. epc_out=pc_cur-4 wraps likewise.
- Cause bits outside [31] and [6:2] are 0.
- Reset asserted in any state aborts immediately: the pending target is discarded and epc_we=0 that cycle.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - RESET_VECTOR and EXC_VECTOR defaults;
  - ExcCode constants: SYSCALL=8, BREAK=9, TEQ=13;
  - Cause bit positions.
- No sub-module is natural. The delay-slot register (pend_valid/pend_target) and flush counter stay inline.

Test Plan:
- Reset held 3 cycles, then released with pc_cur=0x00400000 and no requests -> pc_we=0 during reset; pc_next=0x00400004, pc_we=1 on the first RUN cycle.
- br_taken=1, br_target=0x00400100 at pc_cur=0x00400010 -> pc_next=0x00400014. Next cycle pc_next=0x00400100, pend cleared; a jmp asserted in that slot cycle is ignored.
- exc_req, exc_cause=8 in the delay slot (pc_cur=0x00400014) -> pc_next=0x00400004, epc_we=1, epc_out=0x00400010, cause_out=0x80000020. FLUSH holds pc_we=0 for FLUSH_CYCLES, then RUN.
- stall_req high 4 cycles, entered while pend_valid=1 (target 0x00400100) -> pc_we=0 for 4 cycles; the first RUN cycle after loads 0x00400100.
- eret with epc_in=0x00400020 while exc_req=0 -> pc_next=0x00400020, pc_we=1. Same cycle exc_req=1 -> exception wins, pc_next=0x00400004.
- halt=1 -> pc_we=0 indefinitely, exc_req ignored; rst=1 -> state RUN, pc_next=RESET_VECTOR.

Source files
------------

// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the PC sequencing controller: state encoding,
// default vectors, MIPS ExcCodes and Cause word layout.
package pc_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0040_0004;

  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_EXC_LSB = 2;

  function automatic logic [31:0] make_cause(input logic bd, input logic [4:0] code);
    logic [31:0] c;
    c = '0;
    c[CAUSE_BD] = bd;
    c[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = code;
    return c;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: chooses the next PC, tracks the branch delay slot,
// inserts the post-exception flush bubble and drives the EPC/Cause strobe.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc_req,
  input  logic [4:0]  exc_cause,
  input  logic        eret,
  input  logic [31:0] epc_in,
  input  logic        stall_req,
  input  logic        halt,
  output logic [31:0] pc_next,
  output logic        pc_we,
  output logic [31:0] epc_out,
  output logic [31:0] cause_out,
  output logic        epc_we,
  output logic [1:0]  state_o
);

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic        run_eval;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // The cycle in which stall_req has dropped is evaluated as a RUN cycle.
  assign run_eval = (state_q == ST_RUN) || ((state_q == ST_STALL) && !stall_req);

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    flush_cnt_d   = flush_cnt_q;
    pc_we         = 1'b0;
    pc_next       = pc_cur + 32'd4;
    epc_we        = 1'b0;
    epc_out       = pend_valid_q ? (pc_cur - 32'd4) : pc_cur;
    cause_out     = make_cause(pend_valid_q, exc_cause);

    unique case (state_q)
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 2'd1;
        if (flush_cnt_q <= 2'd1) state_d = ST_RUN;
      end
      default: ;
    endcase

    if (run_eval) begin
      state_d = ST_RUN;
      if (exc_req) begin
        pc_we        = 1'b1;
        pc_next      = EXC_VECTOR;
        epc_we       = 1'b1;
        pend_valid_d = 1'b0;
        flush_cnt_d  = 2'(FLUSH_CYCLES);
        state_d      = ST_FLUSH;
      end else if (eret) begin
        pc_we        = 1'b1;
        pc_next      = epc_in;
        pend_valid_d = 1'b0;
      end else if (stall_req) begin
        state_d = ST_STALL;
      end else if (halt) begin
        state_d = ST_HALT;
      end else if (pend_valid_q) begin
        // Delay slot retires; any branch/jump it carries is dropped.
        pc_we        = 1'b1;
        pc_next      = pend_target_q;
        pend_valid_d = 1'b0;
      end else begin
        pc_we = 1'b1;
        if (jmp) begin
          pend_target_d = jmp_target;
          pend_valid_d  = 1'b1;
        end else if (br_taken) begin
          pend_target_d = br_target;
          pend_valid_d  = 1'b1;
        end
      end
    end

    if (rst) begin
      pc_we   = 1'b0;
      pc_next = RESET_VECTOR;
      epc_we  = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: expected outputs are queued with each
// stimulus cycle and compared on the following falling clock edge.
module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur, br_target, jmp_target, epc_in;
  logic        br_taken, jmp, exc_req, eret, stall_req, halt;
  logic [4:0]  exc_cause;
  logic [31:0] pc_next, epc_out, cause_out;
  logic        pc_we, epc_we;
  logic [1:0]  state_o;

  typedef struct {
    string       tag;
    logic        rst;
    logic        we;
    logic [31:0] nxt;
    logic        ewe;
    logic [31:0] eo;
    logic [31:0] co;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_seq_ctrl dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
    .exc_req(exc_req), .exc_cause(exc_cause),
    .eret(eret), .epc_in(epc_in),
    .stall_req(stall_req), .halt(halt),
    .pc_next(pc_next), .pc_we(pc_we),
    .epc_out(epc_out), .cause_out(cause_out),
    .epc_we(epc_we), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".we"},    32'(pc_we),   32'(e.we));
      chk({e.tag, ".epcwe"}, 32'(epc_we),  32'(e.ewe));
      chk({e.tag, ".state"}, 32'(state_o), 32'(e.st));
      if (e.we || e.rst) chk({e.tag, ".next"}, pc_next, e.nxt);
      if (e.ewe) begin
        chk({e.tag, ".epc"},   epc_out,   e.eo);
        chk({e.tag, ".cause"}, cause_out, e.co);
      end
    end
  end

  task automatic idle(input logic [31:0] pc);
    pc_cur = pc; br_taken = 0; br_target = '0; jmp = 0; jmp_target = '0;
    exc_req = 0; exc_cause = '0; eret = 0; epc_in = '0; stall_req = 0; halt = 0;
  endtask

  task automatic step(input string tag, input logic we, input logic [31:0] nxt,
                      input logic ewe, input logic [31:0] eo, input logic [31:0] co,
                      input logic [1:0] st);
    exp_t e;
    e.tag = tag; e.rst = rst; e.we = we; e.nxt = nxt;
    e.ewe = ewe; e.eo = eo; e.co = co; e.st = st;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    idle(32'h0040_0000);
    @(posedge clk);
    #1;
    // Reset held three cycles
    for (int i = 0; i < 3; i++) step("rst", 0, 32'h0040_0000, 0, 0, 0, 2'd0);
    rst = 0;
    step("run0", 1, 32'h0040_0004, 0, 0, 0, 2'd0);

    // Taken branch, then delay slot with an ignored jump
    idle(32'h0040_0010); br_taken = 1; br_target = 32'h0040_0100;
    step("br", 1, 32'h0040_0014, 0, 0, 0, 2'd0);
    idle(32'h0040_0014); jmp = 1; jmp_target = 32'h0040_0800;
    step("slot", 1, 32'h0040_0100, 0, 0, 0, 2'd0);
    idle(32'h0040_0100);
    step("post", 1, 32'h0040_0104, 0, 0, 0, 2'd0);

    // Syscall in a delay slot
    idle(32'h0040_0010); br_taken = 1; br_target = 32'h0040_0100;
    step("br2", 1, 32'h0040_0014, 0, 0, 0, 2'd0);
    idle(32'h0040_0014); exc_req = 1; exc_cause = 5'd8;
    step("excbd", 1, 32'h0040_0004, 1, 32'h0040_0010, 32'h8000_0020, 2'd0);
    idle(32'h0040_0004); exc_req = 1; eret = 1; jmp = 1; jmp_target = 32'h0040_0900;
    step("flush", 0, 0, 0, 0, 0, 2'd2);
    idle(32'h0040_0004);
    step("aftfl", 1, 32'h0040_0008, 0, 0, 0, 2'd0);

    // Break outside a delay slot
    idle(32'h0040_0040); exc_req = 1; exc_cause = 5'd9;
    step("exc", 1, 32'h0040_0004, 1, 32'h0040_0040, 32'h0000_0024, 2'd0);
    idle(32'h0040_0004);
    step("flush2", 0, 0, 0, 0, 0, 2'd2);
    step("aftfl2", 1, 32'h0040_0008, 0, 0, 0, 2'd0);

    // Four stall cycles entered with a pending branch
    idle(32'h0040_0050); br_taken = 1; br_target = 32'h0040_0100;
    step("br3", 1, 32'h0040_0054, 0, 0, 0, 2'd0);
    idle(32'h0040_0054); stall_req = 1;
    step("stall0", 0, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0, 0, 2'd1);
    stall_req = 0;
    step("unstall", 1, 32'h0040_0100, 0, 0, 0, 2'd1);
    idle(32'h0040_0100);
    step("aftst", 1, 32'h0040_0104, 0, 0, 0, 2'd0);

    // ERET alone, then ERET against a trap
    idle(32'h0040_0104); eret = 1; epc_in = 32'h0040_0020;
    step("eret", 1, 32'h0040_0020, 0, 0, 0, 2'd0);
    idle(32'h0040_0020); eret = 1; epc_in = 32'h0040_0020; exc_req = 1; exc_cause = 5'd13;
    step("excwin", 1, 32'h0040_0004, 1, 32'h0040_0020, 32'h0000_0034, 2'd0);
    idle(32'h0040_0004);
    step("flush3", 0, 0, 0, 0, 0, 2'd2);
    step("aftfl3", 1, 32'h0040_0008, 0, 0, 0, 2'd0);

    // Address wrap on both pc+4 and pc-4
    idle(32'hFFFF_FFFC); br_taken = 1; br_target = 32'h0040_0100;
    step("wrap", 1, 32'h0000_0000, 0, 0, 0, 2'd0);
    idle(32'h0000_0000); exc_req = 1; exc_cause = 5'd8;
    step("wrapepc", 1, 32'h0040_0004, 1, 32'hFFFF_FFFC, 32'h8000_0020, 2'd0);
    idle(32'h0040_0004);
    step("flush4", 0, 0, 0, 0, 0, 2'd2);
    step("aftfl4", 1, 32'h0040_0008, 0, 0, 0, 2'd0);

    // Halt is sticky until reset
    idle(32'h0040_0008); halt = 1;
    step("halt", 0, 0, 0, 0, 0, 2'd0);
    idle(32'h0040_0008); exc_req = 1; exc_cause = 5'd8;
    step("haltexc", 0, 0, 0, 0, 0, 2'd3);
    idle(32'h0040_0008);
    step("halted", 0, 0, 0, 0, 0, 2'd3);
    rst = 1;
    step("haltrst", 0, 32'h0040_0000, 0, 0, 0, 2'd3);
    rst = 0; idle(32'h0040_0000);
    step("rerun", 1, 32'h0040_0004, 0, 0, 0, 2'd0);

    // Reset discards a pending target and suppresses the EPC strobe
    idle(32'h0040_0010); br_taken = 1; br_target = 32'h0040_0100;
    step("br4", 1, 32'h0040_0014, 0, 0, 0, 2'd0);
    rst = 1; idle(32'h0040_0014); exc_req = 1; exc_cause = 5'd8;
    step("rstexc", 0, 32'h0040_0000, 0, 0, 0, 2'd0);
    rst = 0; idle(32'h0040_0000);
    step("rstpend", 1, 32'h0040_0004, 0, 0, 0, 2'd0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d queued expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
